// File: rtl/bus_out_accum_pkg.sv
// bus_out_accum_pkg: shared types and helpers for the bus_out burst accumulator.
//   acc_state_e : burst FSM state encoding (IDLE, ACCUM, HOLD)
//   cnt_width() : width of the in-burst sample counter for a given burst length
package bus_out_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no samples of the current burst taken yet
    ACCUM = 2'd1,  // part of a burst accumulated
    HOLD  = 2'd2   // burst total waiting for the output handshake
  } acc_state_e;

  // Counter must be able to represent 0..burst_len.
  function automatic int cnt_width(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

endpackage

// File: rtl/bus_out_accum_if.sv
// bus_out_accum_if: sample-in / total-out handshake bundle of bus_out_accum.
//   in_valid/in_data/in_bias/in_ready : sample side (bus_out, eee, w2)
//   clear                             : synchronous flush
//   out_valid/out_ready/out_sum       : burst-total side
//   ovf                               : sticky overflow flag
// Modports: master = producer/consumer environment, slave = accumulator.
interface bus_out_accum_if #(
  parameter int DATA_W = 16,
  parameter int BIAS_W = 8,
  parameter int ACC_W  = 32
);
  import bus_out_accum_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [BIAS_W-1:0] in_bias;
  logic              in_ready;
  logic              clear;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              ovf;

  modport master (
    output in_valid, in_data, in_bias, clear, out_ready,
    input  in_ready, out_valid, out_sum, ovf
  );

  modport slave (
    input  in_valid, in_data, in_bias, clear, out_ready,
    output in_ready, out_valid, out_sum, ovf
  );

endinterface

// File: rtl/bus_out_accum_acc_add.sv
// acc_add: combinational three-term adder for the burst accumulator.
//   acc  in  ACC_W   running accumulator
//   data in  DATA_W  unsigned sample
//   bias in  BIAS_W  unsigned side term
//   sum  out ACC_W   reduced result (wrapped, or clamped when saturating)
//   ovf  out 1       result did not fit in ACC_W bits
// Build option: BUS_OUT_ACCUM_SATURATE_EN selects clamping instead of wrapping.
module acc_add
  import bus_out_accum_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int BIAS_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [DATA_W-1:0] data,
  input  logic [BIAS_W-1:0] bias,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  // Two guard bits hold the full three-term result without loss.
  logic [ACC_W+1:0] full;

  assign full = {2'b00, acc} + (ACC_W+2)'(data) + (ACC_W+2)'(bias);
  assign ovf  = |full[ACC_W+1:ACC_W];

`ifdef BUS_OUT_ACCUM_SATURATE_EN
  // A clamped accumulator overflows again on any nonzero add, so it stays clamped.
  assign sum = ovf ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
  assign sum = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/bus_out_accum.sv
// bus_out_accum: sums BURST_LEN bus_out samples (plus w2 bias) per burst and
// presents each total on a registered valid/ready output.
//   clk  : sole clock
//   rst  : asynchronous active-high reset
//   bus  : bus_out_accum_if.slave (sample in, clear, total out, sticky ovf)
// Build option: BUS_OUT_ACCUM_SATURATE_EN (clamp on overflow instead of wrap),
// handled inside acc_add; FSM and handshake are the same in both builds.
module bus_out_accum
  import bus_out_accum_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int BIAS_W    = 8,
  parameter int ACC_W     = 32,
  parameter int BURST_LEN = 4
) (
  input logic           clk,
  input logic           rst,
  bus_out_accum_if.slave bus
);

  localparam int CNT_W = cnt_width(BURST_LEN);

  acc_state_e       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] out_sum_q;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             ovf_q;

  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             accept;
  logic             last;

  acc_add #(
    .DATA_W (DATA_W),
    .BIAS_W (BIAS_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc  (acc),
    .data (bus.in_data),
    .bias (bus.in_bias),
    .sum  (add_sum),
    .ovf  (add_ovf)
  );

  // in_ready is low only in HOLD and during reset, so it already gates accept.
  assign accept = bus.in_valid && in_ready_q;
  assign last   = (cnt == CNT_W'(BURST_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (bus.clear) begin
      // Flush wins over a same-cycle accept; that sample is dropped.
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      ovf_q       <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          // First edge after reset release raises in_ready here.
          in_ready_q <= 1'b1;
          if (accept) begin
            ovf_q <= ovf_q | add_ovf;
            if (last) begin
              out_sum_q   <= add_sum;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
              acc         <= '0;
              cnt         <= '0;
              state       <= HOLD;
            end else begin
              acc   <= add_sum;
              cnt   <= cnt + CNT_W'(1);
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          // out_valid is always 1 in HOLD; no bypass into the next burst.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_bus_out_accum.sv
// tb_bus_out_accum: directed + randomized check of bus_out_accum against a
// plain-arithmetic burst-sum model. DUT built with ACC_W=17 so that random
// bursts and the 0xFFFF/0xFF case reach overflow.
module tb_bus_out_accum;

  localparam int DATA_W = 16;
  localparam int BIAS_W = 8;
  localparam int ACC_W  = 17;
  localparam int BL     = 4;
  localparam longint MAXV = (longint'(1) << ACC_W) - 1;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // reference model state
  longint m_acc;
  int     m_cnt;
  longint m_out;
  bit     m_ovf;

  bus_out_accum_if #(.DATA_W(DATA_W), .BIAS_W(BIAS_W), .ACC_W(ACC_W)) bif ();

  bus_out_accum #(
    .DATA_W(DATA_W), .BIAS_W(BIAS_W), .ACC_W(ACC_W), .BURST_LEN(BL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_acc = 0; m_cnt = 0; m_ovf = 0;
  endtask

  task automatic m_add(input longint d, input longint b);
    m_acc = m_acc + d + b;
    if (m_acc > MAXV) begin
      m_ovf = 1;
`ifdef BUS_OUT_ACCUM_SATURATE_EN
      m_acc = MAXV;
`else
      m_acc = m_acc - (MAXV + 1);
`endif
    end
    m_cnt++;
    if (m_cnt == BL) begin
      m_out = m_acc;
      m_acc = 0;
      m_cnt = 0;
    end
  endtask

  // Present one sample from a negedge and hold it for exactly one accepting edge.
  task automatic accept(input logic [DATA_W-1:0] d, input logic [BIAS_W-1:0] b);
    int n;
    n = 0;
    @(negedge clk);
    bif.in_valid = 1'b1;
    bif.in_data  = d;
    bif.in_bias  = b;
    while (bif.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_at_accept", bif.in_ready, 1);
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
    m_add(d, b);
  endtask

  task automatic gap_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after the edge that took the last sample of a burst.
  task automatic check_out(input string tag);
    chk({tag, "_valid"}, bif.out_valid, 1);
    chk({tag, "_sum"},   bif.out_sum, m_out);
    chk({tag, "_ovf"},   bif.ovf, m_ovf);
    chk({tag, "_rdy0"},  bif.in_ready, 0);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    bif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_hs_valid"}, bif.out_valid, 0);
    chk({tag, "_hs_rdy"},   bif.in_ready, 1);
    bif.out_ready = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    bif.clear = 1'b1;
    @(posedge clk);
    #1;
    bif.clear = 1'b0;
    m_reset();
    chk("clear_valid", bif.out_valid, 0);
    chk("clear_rdy",   bif.in_ready, 1);
    chk("clear_ovf",   bif.ovf, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_reset();
    m_out = 0;
    rst = 1'b1;
    bif.in_valid  = 1'b0;
    bif.in_data   = '0;
    bif.in_bias   = '0;
    bif.clear     = 1'b0;
    bif.out_ready = 1'b0;

    // reset state
    #12;
    chk("rst_rdy",   bif.in_ready, 0);
    chk("rst_valid", bif.out_valid, 0);
    chk("rst_sum",   bif.out_sum, 0);
    chk("rst_ovf",   bif.ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_rdy_before_edge", bif.in_ready, 0);
    @(posedge clk);
    #1;
    chk("rel_rdy_after_edge", bif.in_ready, 1);

    // basic burst
    bif.out_ready = 1'b1;
    accept(16'h0010, 8'h01);
    chk("basic_not_early", bif.out_valid, 0);
    accept(16'h0020, 8'h01);
    accept(16'h0030, 8'h01);
    accept(16'h0040, 8'h01);
    check_out("basic");
    chk("basic_const", bif.out_sum, 17'h000A4);
    handshake("basic");

    // backpressure: three stalled cycles, then handshake
    bif.out_ready = 1'b0;
    for (int i = 0; i < BL; i++) accept(16'($urandom), 8'($urandom));
    check_out("bp");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", bif.out_valid, 1);
      chk("bp_hold_sum",   bif.out_sum, m_out);
      chk("bp_hold_rdy",   bif.in_ready, 0);
    end
    handshake("bp");

    // overflow, sticky across the next burst, cleared by clear
    do_clear();
    for (int i = 0; i < BL; i++) accept(16'hFFFF, 8'hFF);
    check_out("ovf");
`ifdef BUS_OUT_ACCUM_SATURATE_EN
    chk("ovf_const", bif.out_sum, 17'h1FFFF);
`else
    chk("ovf_const", bif.out_sum, 17'h003F8);
`endif
    chk("ovf_set", bif.ovf, 1);
    handshake("ovf");
    for (int i = 0; i < BL; i++) accept(16'h0001, 8'h00);
    check_out("ovf_next");
    chk("ovf_sticky", bif.ovf, 1);
    handshake("ovf_next");
    do_clear();

    // clear mid-burst drops the concurrent sample
    accept(16'h0005, 8'h03);
    accept(16'h0007, 8'h02);
    @(negedge clk);
    bif.clear    = 1'b1;
    bif.in_valid = 1'b1;
    bif.in_data  = 16'h0100;
    bif.in_bias  = 8'h00;
    @(posedge clk);
    #1;
    bif.clear    = 1'b0;
    bif.in_valid = 1'b0;
    m_reset();
    chk("midclr_valid", bif.out_valid, 0);
    for (int i = 0; i < BL; i++) accept(16'h0001, 8'h00);
    check_out("midclr");
    chk("midclr_const", bif.out_sum, 17'h4);
    handshake("midclr");

    // gapped input, then async reset while holding
    for (int i = 0; i < BL; i++) begin
      accept(16'h0002, 8'h00);
      if (i < BL - 1) begin
        gap_cycle();
        chk("gap_no_valid", bif.out_valid, 0);
      end
    end
    check_out("gap");
    chk("gap_const", bif.out_sum, 17'h8);
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    chk("arst_valid", bif.out_valid, 0);
    chk("arst_rdy",   bif.in_ready, 0);
    chk("arst_sum",   bif.out_sum, 0);
    chk("arst_ovf",   bif.ovf, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_rel_rdy0", bif.in_ready, 0);
    @(posedge clk);
    #1;
    chk("arst_rel_rdy1", bif.in_ready, 1);

    // randomized bursts with gaps, backpressure and occasional clears
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 4) == 0) do_clear();
      for (int i = 0; i < BL; i++) begin
        accept(16'($urandom), 8'($urandom));
        if (i < BL - 1 && $urandom_range(0, 1) == 1) gap_cycle();
      end
      check_out("rnd");
      for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
        @(posedge clk);
        #1;
        chk("rnd_stall_sum", bif.out_sum, m_out);
        chk("rnd_stall_rdy", bif.in_ready, 0);
      end
      handshake("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_out_accum.md
# bus_out_accum

Downstream consumer of the extracted `foo`/`bar` datapath. It takes the 16-bit `bus_out` result, qualified by the `eee` strobe, together with the 8-bit `w2` side term. It sums a fixed-length burst of samples into a wide accumulator and presents each burst total on a valid/ready output. It replaces the ad-hoc `Z <= X + Y + bus_out + w2` register in the parent with a flow-controlled, overflow-aware stage.

## Interface

Parameters:
- `DATA_W`, 16: width of `in_data`.
- `BIAS_W`, 8: width of `in_bias`.
- `ACC_W`, 32: accumulator and `out_sum` width; must be greater than `DATA_W`.
- `BURST_LEN`, 4: samples per burst; must be at least 1.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  sample strobe, driven by `eee`.
- `in_data`  in  DATA_W  sample value, unsigned (`bus_out`).
- `in_bias`  in  BIAS_W  per-sample additive term, unsigned (`w2`).
- `in_ready`  out  1  stage accepts a sample this cycle.
- `clear`  in  1  synchronous flush.
- `out_valid`  out  1  `out_sum` holds a completed burst total.
- `out_ready`  in  1  downstream accepts `out_sum`.
- `out_sum`  out  ACC_W  burst total.
- `ovf`  out  1  sticky overflow flag.

## Operation

- Sample accept: `in_valid && in_ready`, evaluated at the `clk` edge.
- Per accept: `acc_next = acc + zext(in_data) + zext(in_bias)`, computed at ACC_W+2 bits, then reduced per Configuration. `cnt` increments.
- FSM states:
  - IDLE: `cnt`=0, `in_ready`=1.
  - ACCUM: 0<`cnt`<BURST_LEN, `in_ready`=1.
  - HOLD: result pending, `in_ready`=0.
- Transitions:
  - IDLE→ACCUM on accept. With BURST_LEN=1, IDLE→HOLD instead.
  - ACCUM→HOLD on the accept that makes `cnt`=BURST_LEN. On that edge: `out_sum`←`acc_next`, `acc`←0, `cnt`←0.
  - HOLD→IDLE on `out_valid && out_ready`.
- Input gaps are allowed: `in_valid` low in ACCUM holds `acc` and `cnt` unchanged.
- `out_sum` and `out_valid` are registered. `out_sum` stays stable while `out_valid && !out_ready`.
- `clear`:
  - Sends any state to IDLE. Zeroes `acc` and `cnt`. Drops `out_valid` and discards a pending result.
  - Clears `ovf`.
  - Takes priority over a same-cycle accept; that sample is dropped.
- `ovf`: set on any overflowing add. Remains set until `clear` or `rst`. Never set by `clear` itself.
- Reset values:
  - `in_ready`=0, `out_valid`=0, `out_sum`=0, `ovf`=0.
  - `acc`=0, `cnt`=0, state IDLE.
- `in_ready` is registered. It rises on the first `clk` edge after `rst` deasserts.

## Timing

- Latency: the accept of the last burst sample at edge N gives `out_valid`=1 after edge N.
- In HOLD, `in_ready` is 0 in the same cycles that `out_valid` is 1.
- After the output handshake at edge M, `in_ready` is 1 after edge M. No bypass.
- Minimum burst period is BURST_LEN+1 cycles.
- Asserting `rst` at any time, including mid-HOLD, forces all outputs to reset values immediately, with no clock needed.

## Configuration

- Macro: `BUS_OUT_ACCUM_SATURATE_EN`.
- Defined: an overflowing add clamps `acc` to 2^ACC_W−1 and sets `ovf`. Further adds in the burst stay clamped.
- Undefined: adds wrap modulo 2^ACC_W, and `ovf` is set on any carry out of bit ACC_W−1.
- FSM and handshake behaviour are identical in both builds.

## Structure

- Shared package `bus_out_accum_pkg`:
  - FSM state enum `acc_state_e` (IDLE, ACCUM, HOLD).
  - Localparam function for `cnt` width, `$clog2(BURST_LEN+1)`.
- One sub-module, `acc_add`:
  - Combinational three-term adder.
  - Produces the reduced sum and an overflow bit.
  - Contains the `BUS_OUT_ACCUM_SATURATE_EN` branch.
- FSM, counters and output register live in `bus_out_accum`.

## Test plan

- Basic burst: BURST_LEN=4, back-to-back data 0x0010/0x0020/0x0030/0x0040, bias 0x01, `out_ready`=1 → `out_valid` one cycle after the 4th accept, `out_sum`=0x000000A4, `ovf`=0.
- Backpressure: hold `out_ready` low 3 cycles in HOLD → `out_valid` and `out_sum` stable, `in_ready`=0. Handshake on cycle 4 → `in_ready`=1 the next cycle.
- Overflow: ACC_W=17, 4× (data 0xFFFF, bias 0xFF) → wrap build `out_sum`=0x003F8; saturate build `out_sum`=0x1FFFF; `ovf`=1 in both, stays 1 across the next burst until `clear`.
- Clear mid-burst: 2 samples accepted, then `clear` with `in_valid`=1 and data 0x0100 → that sample is dropped. The next 4 samples of 0x0001 with bias 0 give `out_sum`=0x4.
- Gapped input plus reset: `in_valid` alternating 1/0 over 4 samples of 0x0002 with bias 0 → `out_sum`=0x8. Then assert `rst` during HOLD → `out_valid`=0 immediately, and `in_ready`=0 until one edge after release.
